// File: rtl/fetch_prefetch_queue.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fetch_prefetch_queue : {instr, next-PC} FIFO between fetch and IF/ID,    |
// | flushed in one cycle on a taken branch. Option macro: PREFETCH_BYPASS_EN |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module fetch_prefetch_queue #(
  parameter int INSTR_W = 16,
  parameter int PC_W    = 10,
  parameter int DEPTH   = 4,
  parameter int CNT_W   = $clog2(DEPTH) + 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               iFlush,
  input  logic               iValid,
  input  logic [INSTR_W-1:0] iInstr,
  input  logic [PC_W-1:0]    iNewPC,
  output logic               oReady,
  output logic               oValid,
  output logic [INSTR_W-1:0] oInstr,
  output logic [PC_W-1:0]    oNewPC,
  input  logic               iReady,
  output logic [CNT_W-1:0]   oCount,
  output logic               oOverflowErr
);

  localparam int             PTR_W       = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] C_DEPTH_CNT = CNT_W'(DEPTH);

  logic [INSTR_W-1:0] r_instr [DEPTH];
  logic [PC_W-1:0]    r_pc    [DEPTH];
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [CNT_W-1:0]   r_count;
  logic               r_ovf;

  logic w_full;
  logic w_empty;
  logic w_fall;
  logic w_bypass;
  logic w_push;
  logic w_pop;

  always_comb begin
    w_full  = (r_count == C_DEPTH_CNT);
    w_empty = (r_count == '0);
`ifdef PREFETCH_BYPASS_EN
    // Empty queue presents the fetch word directly; if decode takes it, skip storage.
    w_fall   = w_empty & iValid & ~iFlush;
    w_bypass = w_fall & iReady;
`else
    w_fall   = 1'b0;
    w_bypass = 1'b0;
`endif
    w_push = iValid & ~w_full & ~w_bypass;
    w_pop  = ~w_empty & iReady;
  end

  always_comb begin
    oReady       = ~w_full;
    oCount       = r_count;
    oOverflowErr = r_ovf;
    oValid       = 1'b0;
    oInstr       = '0;
    oNewPC       = '0;
    if (!w_empty) begin
      oValid = 1'b1;
      oInstr = r_instr[r_rd_ptr];
      oNewPC = r_pc[r_rd_ptr];
    end else if (w_fall) begin
      oValid = 1'b1;
      oInstr = iInstr;
      oNewPC = iNewPC;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      r_ovf    <= 1'b0;
    end else begin
      if (iValid && w_full) begin
        r_ovf <= 1'b1;
      end
      if (iFlush) begin
        r_rd_ptr <= '0;
        r_wr_ptr <= '0;
        r_count  <= '0;
      end else begin
        if (w_push) begin
          r_wr_ptr <= r_wr_ptr + PTR_W'(1);
        end
        if (w_pop) begin
          r_rd_ptr <= r_rd_ptr + PTR_W'(1);
        end
        case ({w_push, w_pop})
          2'b10:   r_count <= r_count + CNT_W'(1);
          2'b01:   r_count <= r_count - CNT_W'(1);
          default: r_count <= r_count;
        endcase
      end
    end
  end

  // Storage needs no reset: reads are masked whenever the queue is empty.
  always_ff @(posedge clk) begin
    if (!reset && !iFlush && w_push) begin
      r_instr[r_wr_ptr] <= iInstr;
      r_pc[r_wr_ptr]    <= iNewPC;
    end
  end

endmodule
`default_nettype wire

// File: doc/fetch_prefetch_queue.md
Name: fetch_prefetch_queue

Overview:
- Small FIFO between the fetch stage and the IF/ID pipeline register.
- Decouples instruction fetch from decode stalls. Buffers up to DEPTH {instruction, new-PC} pairs and presents the oldest one to decode.
- A taken branch from the execute stage flushes all buffered (wrong-path) entries in one cycle.

Parameters:
- INSTR_W, 16, width of a fetched instruction word.
- PC_W, 10, width of the next-PC value carried with each instruction.
- DEPTH, 4, number of entries; must be a power of two, minimum 2.
- CNT_W, $clog2(DEPTH)+1, width of the occupancy counter.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- iFlush  in  1  branch taken in execute; discards all entries.
- iValid  in  1  fetch presents a valid instruction this cycle.
- iInstr  in  INSTR_W  fetched instruction.
- iNewPC  in  PC_W  PC+1 associated with iInstr.
- oReady  out  1  queue can accept a push this cycle.
- oValid  out  1  head entry valid for decode.
- oInstr  out  INSTR_W  head instruction.
- oNewPC  out  PC_W  head next-PC.
- iReady  in  1  decode consumes the head this cycle.
- oCount  out  CNT_W  current occupancy, 0..DEPTH.
- oOverflowErr  out  1  sticky flag: push attempted while full.

Behaviour:
- Reset (reset=1 at rising edge):
  - rd_ptr=0, wr_ptr=0, count=0, oOverflowErr=0.
  - Outputs after reset: oValid=0, oReady=1, oCount=0; oInstr/oNewPC=0.
  - Storage contents are don't-care.
- Reset mid-operation discards everything, exactly like a flush, and also clears oOverflowErr.
- Push = iValid & oReady. Pop = oValid & iReady.
- oReady = (count != DEPTH). oValid = (count != 0).
- oInstr/oNewPC are driven from storage[rd_ptr] (mux of registered entries). When oValid=0 they read 0.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. The count is the extra-bit counter and is the sole full/empty source.
- Latency: an entry pushed at edge N is visible on oValid/oInstr after edge N (1 cycle, no bypass; see Optional Feature).
- Simultaneous push and pop:
  - When 0<count<DEPTH, both occur and count is unchanged.
  - When full, oReady=0, so only the pop occurs. A push is never accepted in the same cycle a full queue pops (no combinational ready-from-pop path).
  - When empty, only the push occurs (oValid=0, so no pop).
- iValid=1 while full: the entry is not written, and oOverflowErr is set and stays 1 until reset. Fetch is expected to hold its value; the flag is diagnostic only.
- Flush (iFlush=1, reset=0):
  - rd_ptr=wr_ptr=0 and count=0 at the edge.
  - A push or pop in the same cycle is ignored; flush has priority over both.
  - oOverflowErr is unaffected.
  - Next cycle: oValid=0, oReady=1.
- Priority order: reset > iFlush > push/pop.
- No state machine beyond the pointers and counter.
- No X propagation: outputs are defined every cycle after the first reset.

Optional Feature:
- Macro PREFETCH_BYPASS_EN.
- When defined, an empty queue falls through combinationally:
  - If count==0 and iValid=1 and iFlush=0, then oValid=1, oInstr=iInstr, oNewPC=iNewPC in the same cycle.
  - If iReady=1 in that cycle, the entry is consumed: nothing is written and the count stays 0.
  - If iReady=0, it is written normally.
  - Empty-to-decode latency is 0 cycles.
- When not defined, oValid/oInstr/oNewPC depend only on registered state; latency is 1 cycle.
- oReady, oCount and oOverflowErr are identical in both builds.

Test Plan:
- Reset then fill: reset for 2 cycles; push 0x1111/PC 0x001 … 0x4444/PC 0x004 with iReady=0 -> oCount=4, oReady=0, oValid=1, oInstr=0x1111, oNewPC=0x001.
- Drain in order, with wrap: from full, iReady=1 for 4 cycles -> oInstr sequence 0x1111, 0x2222, 0x3333, 0x4444; then oValid=0, oCount=0. Push 6 more entries, interleaving pops, so that both pointers wrap -> order preserved.
- Simultaneous push/pop at count=2: iValid=1 (0xAAAA), iReady=1 -> head advances, oCount stays 2, 0xAAAA is delivered third.
- Flush priority: count=3, assert iFlush with iValid=1 (0xBBBB) and iReady=1 -> next cycle oCount=0, oValid=0, oReady=1; 0xBBBB is never delivered.
- Overflow and reset: full with iReady=0, iValid=1 (0xCCCC) -> oOverflowErr=1, oCount=4, 0xCCCC absent. Assert reset mid-stream -> next cycle oOverflowErr=0, oCount=0, oValid=0.
- Bypass (PREFETCH_BYPASS_EN defined): empty, iValid=1 (0x5A5A, PC 0x010), iReady=1 -> same cycle oValid=1, oInstr=0x5A5A; after the edge oCount=0. Without the macro, the same stimulus gives oValid=0 that cycle and oInstr=0x5A5A one cycle later.
